// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared encodings and latency defaults for the multiply/divide controller
package muldiv_ctrl_pkg;

    // Operation codes as issued by the E-stage decoder
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mulop_t;

    // Controller state: waiting for an issue, or counting down an operation
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Used to size the latency counter for whichever operation is slower
    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - combinational multiply/divide datapath producing HI/LO results
module muldiv_alu
    import muldiv_ctrl_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  mulop_t      i_op,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div_zero
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;

    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'h0, i_a} * {32'h0, i_b};

    // A zero divisor is replaced by one so the divider never sees x/0;
    // the controller discards the result via o_div_zero anyway.
    assign w_div_b = (i_b == 32'd0) ? 32'd1 : i_b;

    assign w_uq = i_a / w_div_b;
    assign w_ur = i_a % w_div_b;

    // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 as an
    // unsigned value, so the INT_MIN / -1 case falls out without a special path.
    assign w_a_neg = i_a[31];
    assign w_b_neg = w_div_b[31];
    assign w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = w_b_neg ? (~w_div_b + 32'd1) : w_div_b;
    assign w_mag_q = w_a_mag / w_b_mag;
    assign w_mag_r = w_a_mag % w_b_mag;

    assign o_div_zero = (i_b == 32'd0) && ((i_op == MD_DIV) || (i_op == MD_DIVU));

    // Result select: quotient truncates toward zero, remainder follows dividend sign
    always_comb begin
        o_hi_res = 32'd0;
        o_lo_res = 32'd0;
        case (i_op)
            MD_MULT: begin
                o_hi_res = w_sprod[63:32];
                o_lo_res = w_sprod[31:0];
            end
            MD_MULTU: begin
                o_hi_res = w_uprod[63:32];
                o_lo_res = w_uprod[31:0];
            end
            MD_DIV: begin
                o_lo_res = (w_a_neg ^ w_b_neg) ? (~w_mag_q + 32'd1) : w_mag_q;
                o_hi_res = w_a_neg ? (~w_mag_r + 32'd1) : w_mag_r;
            end
            MD_DIVU: begin
                o_lo_res = w_uq;
                o_hi_res = w_ur;
            end
            default: begin
                o_hi_res = 32'd0;
                o_lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multiply/divide sequencer with HI/LO registers and D-stage stall
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mulop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    mulop_t           r_op;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_last;
    logic             w_accept;
    logic             w_commit;
    logic             w_mtx_ok;
    logic [31:0]      w_hi_res;
    logic [31:0]      w_lo_res;
    logic             w_div_zero;

    muldiv_alu u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_hi_res   (w_hi_res),
        .o_lo_res   (w_lo_res),
        .o_div_zero (w_div_zero)
    );

    assign w_last = (r_count == CNT_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an issue in IDLE starts the countdown, the last count ends it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last) w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // Control decode: issue acceptance, result commit, and mthi/mtlo gating
    always_comb begin
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_mtx_ok = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = start;
                w_mtx_ok = !start;
            end
            ST_BUSY: begin
                w_commit = w_last && !w_div_zero;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // Registered busy flag mirrors the upcoming state so it is glitch-free at the output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_BUSY);
        end
    end

    // Latency counter: loaded on issue, counts down while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= mulop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_state == ST_BUSY) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Operand latches hold the issue values so E-stage operands may change freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_op <= MD_MULT;
        end else if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= mulop_t'(mulop);
        end
    end

    // HI/LO: unit results on the final count, otherwise mthi/mtlo when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
        end else if (w_mtx_ok) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    assign busy  = r_busy;
    assign stall = md_use && (start || r_busy);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mulop;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mulop  (mulop),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .md_use (md_use),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions
    task automatic model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] rh, inout logic [31:0] rl);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = {32'h0, x} * {32'h0, y}; rh = p[63:32]; rl = p[31:0]; end
            2'd2: if (y != 0) begin
                q = sx / sy; r = sx % sy;
                p = 64'(q); rl = p[31:0];
                p = 64'(r); rh = p[31:0];
            end
            default: if (y != 0) begin rl = x / y; rh = x % y; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1; returns in cycle N+1 with results checked
    task automatic op_run(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic use_md, input logic we_at_issue, input logic we_mid);
        int n;
        n = (op < 2) ? MC : DC;
        start = 1'b1; mulop = op; a = x; b = y; md_use = use_md;
        lo_we = we_at_issue; wdata = $urandom;
        #1;
        chk("stall_c0", {31'd0, stall}, {31'd0, use_md});
        for (int c = 1; c <= n; c++) begin
            tick();
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("hi_hold", hi, m_hi);
            chk("lo_hold", lo, m_lo);
            start = 1'b0; a = $urandom; b = $urandom; mulop = 2'($urandom);
            lo_we = we_mid && (c == 2); wdata = $urandom;
            #1;
            chk("stall_busy", {31'd0, stall}, {31'd0, use_md});
        end
        tick();
        lo_we = 1'b0;
        model(op, x, y, m_hi, m_lo);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("hi_res", hi, m_hi);
        chk("lo_res", lo, m_lo);
    endtask

    task automatic mtx(input logic wh, input logic wl, input logic [31:0] d);
        hi_we = wh; lo_we = wl; wdata = d;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        chk("mtx_hi", hi, m_hi);
        chk("mtx_lo", lo, m_lo);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; mulop = 2'd0; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; md_use = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // mthi, then both strobes together
        mtx(1'b1, 1'b0, 32'hDEADBEEF);
        chk("mthi_const", hi, 32'hDEADBEEF);
        mtx(1'b1, 1'b1, 32'hA5A5_0F0F);

        // Directed mult/multu with stall observation
        op_run(2'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        chk("stall_after", {31'd0, stall}, 32'd0);
        op_run(2'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // Directed divides, back-to-back issue in the first non-busy cycle
        op_run(2'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        op_run(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        op_run(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        // Divide by zero keeps prior HI/LO
        mtx(1'b1, 1'b0, 32'h1234);
        mtx(1'b0, 1'b1, 32'h5678);
        op_run(2'd2, 32'd99, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);
        op_run(2'd3, 32'd99, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("dzu_lo", lo, 32'h5678);

        // mtlo while busy, and lo_we alongside start, are both dropped
        op_run(2'd1, 32'd10, 32'd20, 1'b1, 1'b0, 1'b1);
        chk("mid_we_lo", lo, 32'd200);
        op_run(2'd3, 32'd50, 32'd7, 1'b0, 1'b1, 1'b0);
        chk("issue_we_lo", lo, 32'd7);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            op_run(rop, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) mtx(1'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) tick();
        end

        // Reset asserted mid-divide (count 4, cycle 7) acts immediately
        mtx(1'b1, 1'b1, 32'h0BAD_F00D);
        start = 1'b1; mulop = 2'd2; a = 32'd1000; b = 32'd3; md_use = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_lo", lo, m_lo);
        end
        op_run(2'd0, 32'd6, 32'd7, 1'b1, 1'b0, 1'b0);
        chk("post_rst_mult", lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the pipeline's multiply/divide resource. It accepts a mult/multu/div/divu issue from the E stage, latches operands, models the fixed unit latency with a down-counter, and commits the results to the architectural HI/LO registers. It also handles mthi/mtlo writes and raises the stall request that holds the D stage while HI/LO are not yet valid.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (minimum 1).
- DIV_CYCLES, default 10: busy cycles for div/divu (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  E-stage issue of mult/multu/div/divu (decoder m||d).
- mulop  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu; sampled only with start.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- hi_we  in  1  mthi write strobe from E.
- lo_we  in  1  mtlo write strobe from E.
- wdata  in  32  mthi/mtlo data.
- md_use  in  1  D-stage instruction uses the unit (mult/div/mfhi/mflo/mthi/mtlo).
- busy  out  1  registered; high while an operation is in flight.
- stall  out  1  combinational: md_use && (start || busy).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

## Operation
- States: IDLE, BUSY. Reset: IDLE, count=0, busy=0, hi=0, lo=0, operand latches=0.
- IDLE, start=1: latch a, b, mulop; count <= MULT_CYCLES (mulop 0/1) or DIV_CYCLES (mulop 2/3); go BUSY.
- BUSY: count decrements each cycle. On the edge where count==1, write results to HI/LO, clear busy and return to IDLE.
- Arithmetic on latched operands:
  - mult: signed 64-bit product, HI=[63:32], LO=[31:0].
  - multu: the same product, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (b==0, div or divu): full DIV_CYCLES elapse; HI/LO keep their prior values.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- hi_we/lo_we in IDLE with start=0: HI/LO <= wdata on the next edge. hi_we and lo_we may both be set; both registers are then written.
- Dropped events:
  - Writes while BUSY, or in the same cycle as start, are dropped.
  - start while BUSY is ignored; the bench asserts this never occurs.
- Reset mid-operation: the in-flight result is discarded; IDLE, HI/LO=0 on assertion.

## Timing
- Issue at cycle 0 (start=1). busy is high in cycles 1..N, where N is the op's latency. New HI/LO are visible in cycle N+1, when busy=0.
- stall is high in cycle 0 (through start) and cycles 1..N (through busy), whenever md_use=1. A D-stage mfhi therefore reads the committed result in cycle N+1 at the earliest.
- With N=1: busy is high for exactly cycle 1; results are visible in cycle 2.
- An mthi/mtlo write in cycle k is visible on hi/lo in cycle k+1.
- hi and lo are driven directly from registers; there is no bypass of in-flight results.
- Back-to-back issue: start may reassert in cycle N+1, the first cycle with busy=0.

## Structure
- A shared package holds:
  - the mulop encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3);
  - the state encoding;
  - the MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module muldiv_alu: purely combinational. Takes the latched operands and mulop; produces hi_res[31:0], lo_res[31:0] and a div-by-zero flag.
- muldiv_ctrl owns the FSM, counter, operand latches, HI/LO registers and stall logic.

## Test plan
- Reset: after reset, hi=0, lo=0, busy=0. Pulse reset during a div in count 4: hi/lo return to 0 and busy drops immediately.
- mult a=0xFFFFFFFE (-2), b=3: busy high in cycles 1..5; cycle 6 shows hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9 (-7), b=2: busy in cycles 1..10; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2: lo=3, hi=1.
- Divide by zero with prior hi=0x1234, lo=0x5678: busy lasts 10 cycles; hi/lo remain 0x1234/0x5678.
- Stall: md_use=1 during issue and all busy cycles gives stall=1 in cycles 0..5 (mult); md_use=0 gives stall=0 throughout.
- mthi: wdata=0xDEADBEEF in IDLE, so hi=0xDEADBEEF next cycle. An mtlo pulse while BUSY is dropped and lo takes the op result. start with a simultaneous lo_we: the write is dropped.
